// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: state encoding,
// BCD width and parameter-range limits.
package seven_seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam int BCD_W            = 4;
   localparam int MIN_DIGITS       = 2;
   localparam int MAX_DIGITS       = 8;
   localparam int MIN_BLANK_CYCLES = 1;
   localparam int MIN_DWELL_CYCLES = 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int clamp_int(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
// Phase timer for the scan FSM: counts up from zero and flags the last cycle
// of the currently loaded phase length; load restarts it with a new length.
module scan_timer #(
   parameter int CW          = 2,
   parameter int RESET_LIMIT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   output logic [CW-1:0] count,
   output logic          tc
);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] limit_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
         limit_reg <= CW'(RESET_LIMIT);
      end else if (load) begin
         count_reg <= '0;
         limit_reg <= load_value;
      end else if (!tc) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   assign count = count_reg;
   assign tc    = (count_reg == limit_reg - CW'(1));

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a shared BCD-to-7-segment decoder.
// Optional leading-zero suppression: define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int BLANK_CYCLES = 2,
   parameter int DWELL_CYCLES = 50000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        wr_valid,
   input  logic [BCD_W*NUM_DIGITS-1:0] wr_data,
   output logic                        wr_ready,
   output logic [BCD_W-1:0]            bcd_out,
   output logic [NUM_DIGITS-1:0]       digit_en,
   output logic                        frame_done
);

   localparam int SCAN_DIGITS = clamp_int(NUM_DIGITS, MIN_DIGITS, MAX_DIGITS);
   localparam int BLANK_LEN   = max_int(BLANK_CYCLES, MIN_BLANK_CYCLES);
   localparam int DWELL_LEN   = max_int(DWELL_CYCLES, MIN_DWELL_CYCLES);
   localparam int CW          = $clog2(max_int(BLANK_LEN, DWELL_LEN) + 1);
   localparam int IDX_W       = $clog2(NUM_DIGITS);
   localparam int DATA_W      = BCD_W * NUM_DIGITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCAN_DIGITS - 1);

   scan_state_t           state_reg;
   logic [IDX_W-1:0]      index_reg;
   logic [DATA_W-1:0]     display_reg;
   logic [DATA_W-1:0]     shadow_reg;
   logic                  pending_reg;
   logic                  wr_ready_reg;
   logic [BCD_W-1:0]      bcd_out_reg;
   logic [NUM_DIGITS-1:0] digit_en_reg;
   logic                  frame_done_reg;

   logic [CW-1:0]         count;
   logic                  tc;
   logic                  timer_load;
   logic [CW-1:0]         timer_value;

   logic                  transfer;
   logic                  frame_end;
   logic                  commit;
   logic                  last_show_next;
   logic [IDX_W-1:0]      index_next;
   logic [DATA_W-1:0]     display_next;
   logic [BCD_W-1:0]      digit_next [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] show_mask;

   scan_timer #(
      .CW          (CW),
      .RESET_LIMIT (BLANK_LEN)
   ) u_scan_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_value),
      .count      (count),
      .tc         (tc)
   );

   // Each phase change restarts the timer with the length of the phase being entered.
   always_comb begin
      timer_load  = 1'b0;
      timer_value = CW'(BLANK_LEN);
      if (!en) begin
         timer_load = 1'b1;
      end else if (tc) begin
         timer_load  = 1'b1;
         timer_value = (state_reg == BLANK) ? CW'(DWELL_LEN) : CW'(BLANK_LEN);
      end
   end

   assign transfer     = wr_valid && wr_ready_reg;
   assign frame_end    = (state_reg == SHOW) && tc && (index_reg == LAST_IDX);
   assign commit       = pending_reg && (frame_end || !en);
   assign display_next = commit ? shadow_reg : display_reg;
   assign index_next   = (index_reg == LAST_IDX) ? '0 : index_reg + IDX_W'(1);

   // frame_done is registered, so it is raised on the edge entering the final SHOW cycle.
   assign last_show_next = en && (index_reg == LAST_IDX) &&
                           (((state_reg == SHOW) && !tc && (DWELL_LEN >= 2) &&
                             (count == CW'(DWELL_LEN - 2))) ||
                            ((state_reg == BLANK) && tc && (DWELL_LEN == 1)));

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_next[gi] = display_next[gi*BCD_W +: BCD_W];
   end

`ifdef SEVEN_SEG_LZ_BLANK_EN
   logic [NUM_DIGITS-1:1] digit_nz;
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_units
         assign show_mask[gi] = 1'b1;
      end else begin : g_upper
         assign digit_nz[gi]  = |display_reg[gi*BCD_W +: BCD_W];
         assign show_mask[gi] = |digit_nz[NUM_DIGITS-1:gi];
      end
   end
`else
   assign show_mask = '1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= BLANK;
         index_reg      <= '0;
         display_reg    <= '0;
         shadow_reg     <= '0;
         pending_reg    <= 1'b0;
         wr_ready_reg   <= 1'b1;
         bcd_out_reg    <= '0;
         digit_en_reg   <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         if (transfer) begin
            shadow_reg   <= wr_data;
            pending_reg  <= 1'b1;
            wr_ready_reg <= 1'b0;
         end else if (commit) begin
            display_reg  <= shadow_reg;
            pending_reg  <= 1'b0;
            wr_ready_reg <= 1'b1;
         end

         frame_done_reg <= last_show_next;

         if (!en) begin
            state_reg    <= BLANK;
            index_reg    <= '0;
            digit_en_reg <= '0;
            bcd_out_reg  <= digit_next[0];
         end else if (tc) begin
            case (state_reg)
               BLANK: begin
                  state_reg    <= SHOW;
                  digit_en_reg <= show_mask & (NUM_DIGITS'(1) << index_reg);
               end
               SHOW: begin
                  state_reg    <= BLANK;
                  index_reg    <= index_next;
                  digit_en_reg <= '0;
                  bcd_out_reg  <= digit_next[index_next];
               end
               default: state_reg <= BLANK;
            endcase
         end
      end
   end

   assign wr_ready   = wr_ready_reg;
   assign bcd_out    = bcd_out_reg;
   assign digit_en   = digit_en_reg;
   assign frame_done = frame_done_reg;

endmodule
